// File: rtl/irq_aggregator_slave.sv
// irq_aggregator_slave
// Collects NUM_IRQ asynchronous level interrupt sources into a PENDING
// register (edge or level capture), masks them, and drives a single
// registered irq_out to the host. After the host services an interrupt,
// a programmable hold-off keeps irq_out low for a minimum number of cycles.
// Register access uses a simple read/write strobe slave with one-cycle
// read latency.
module irq_aggregator_slave #(
    parameter int NUM_IRQ    = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_IRQ-1:0]    irq_in,
    input  logic [1:0]            address,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdatavalid,
    output logic                  irq_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [NUM_IRQ-1:0]    sync_1;
    logic [NUM_IRQ-1:0]    sync_irq;
    logic [NUM_IRQ-1:0]    sync_prev;
    logic [NUM_IRQ-1:0]    pending;
    logic [NUM_IRQ-1:0]    mask;
    logic [NUM_IRQ-1:0]    set_bits;
    logic [NUM_IRQ-1:0]    clr_bits;
    logic                  ctrl_enable;
    logic                  ctrl_level;
    logic [15:0]           holdoff;
    logic [1:0]            state;
    logic [1:0]            state_nx;
    logic [15:0]           count;
    logic [15:0]           count_nx;
    logic                  active;
    logic                  enable_nx;
    logic                  wr_pending;
    logic                  wr_mask;
    logic                  wr_ctrl;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic                  unused_wdata;

    // Bits of writedata above NUM_IRQ-1 and CTRL bits 15:2 are ignored.
    assign unused_wdata = ^writedata;

    assign wr_pending = write && (address == 2'd0);
    assign wr_mask    = write && (address == 2'd1);
    assign wr_ctrl    = write && (address == 2'd3);

    // sync_prev starts at 0 out of reset, so a source already high at
    // release still produces an edge.
    assign set_bits  = ctrl_level ? sync_irq : (sync_irq & ~sync_prev);
    assign clr_bits  = wr_pending ? writedata[NUM_IRQ-1:0] : '0;
    assign active    = ctrl_enable && (|(pending & mask));
    assign enable_nx = wr_ctrl ? writedata[0] : ctrl_enable;

    // Two-flop synchronizer plus one history stage for edge detection
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_1    <= '0;
            sync_irq  <= '0;
            sync_prev <= '0;
        end else begin
            sync_1    <= irq_in;
            sync_irq  <= sync_1;
            sync_prev <= sync_irq;
        end
    end

    // Register file: PENDING (set wins over W1C), MASK and CTRL
    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending     <= '0;
            mask        <= '0;
            ctrl_enable <= 1'b0;
            ctrl_level  <= 1'b0;
            holdoff     <= '0;
        end else begin
            pending <= (pending & ~clr_bits) | set_bits;
            if (wr_mask) begin
                mask <= writedata[NUM_IRQ-1:0];
            end
            if (wr_ctrl) begin
                ctrl_enable <= writedata[0];
                ctrl_level  <= writedata[1];
                holdoff     <= writedata[31:16];
            end
        end
    end

    // Read mux over current (pre-write) register contents
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[NUM_IRQ-1:0] = pending;
            2'd1:    rd_mux[NUM_IRQ-1:0] = mask;
            2'd2:    rd_mux[NUM_IRQ-1:0] = sync_irq;
            default: begin
                rd_mux[0]     = ctrl_enable;
                rd_mux[1]     = ctrl_level;
                rd_mux[31:16] = holdoff;
            end
        endcase
    end

    // Read response one cycle after the strobe; data held between reads
    always_ff @(posedge clk) begin
        if (!resetn) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

    // Interrupt state machine next-state and hold-off counter
    always_comb begin
        state_nx = state;
        count_nx = count;
        case (state)
            ST_IDLE: begin
                if (active) begin
                    state_nx = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (!active) begin
                    if (holdoff != 16'd0) begin
                        state_nx = ST_HOLDOFF;
                        count_nx = holdoff;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            ST_HOLDOFF: begin
                // The cycle the count expires is the IDLE decision point, so
                // pending work collected during hold-off is taken immediately
                // and irq_out stays low for exactly HOLDOFF cycles.
                if (count <= 16'd1) begin
                    count_nx = '0;
                    state_nx = active ? ST_ASSERT : ST_IDLE;
                end else begin
                    count_nx = count - 16'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                count_nx = '0;
            end
        endcase
        // Disabling (or staying disabled) parks the machine in IDLE.
        if (!enable_nx) begin
            state_nx = ST_IDLE;
            count_nx = '0;
        end
    end

    // State, counter and registered irq_out
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            count   <= '0;
            irq_out <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            irq_out <= (state_nx == ST_ASSERT);
        end
    end

endmodule

// File: tb/tb_irq_aggregator_slave.sv
// Self-checking bench for irq_aggregator_slave: directed scenarios plus a
// randomized phase, all compared against a behavioural model that tracks
// the interrupt output as "asserted" plus a remaining hold-off cycle count.
module tb_irq_aggregator_slave;

    localparam int N = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic [N-1:0]  irq_in;
    logic [1:0]    address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          readdatavalid;
    logic          irq_out;

    int n_tests = 0;
    int n_fail  = 0;

    irq_aggregator_slave #(.NUM_IRQ(N), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .irq_in        (irq_in),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .irq_out       (irq_out)
    );

    always #5 clk = ~clk;

    // Behavioural model
    bit [N-1:0] m_s1, m_s2, m_prev, m_pend, m_mask;
    bit         m_en, m_lvl, m_asserted, m_rdv;
    bit [15:0]  m_hold;
    bit [31:0]  m_rd;
    int         m_left;
    bit         m_act, m_en_after;
    bit [N-1:0] m_set, m_clr;

    function automatic bit [31:0] reg_view(input logic [1:0] a);
        bit [31:0] v;
        v = 32'h0;
        case (a)
            2'd0: v[N-1:0] = m_pend;
            2'd1: v[N-1:0] = m_mask;
            2'd2: v[N-1:0] = m_s2;
            default: v = {m_hold, 14'h0, m_lvl, m_en};
        endcase
        return v;
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_s1 = '0; m_s2 = '0; m_prev = '0; m_pend = '0; m_mask = '0;
            m_en = 0; m_lvl = 0; m_hold = '0; m_asserted = 0; m_left = 0;
            m_rd = '0; m_rdv = 0;
        end else begin
            m_act = m_en && ((m_pend & m_mask) != 0);
            m_rdv = read;
            if (read) m_rd = reg_view(address);
            m_en_after = (write && address == 2'd3) ? writedata[0] : m_en;
            if (!m_en_after) begin
                m_asserted = 0;
                m_left = 0;
            end else if (m_left > 0) begin
                if (m_left == 1) begin
                    m_left = 0;
                    m_asserted = m_act;
                end else begin
                    m_left = m_left - 1;
                end
            end else if (m_asserted) begin
                if (!m_act) begin
                    m_asserted = 0;
                    m_left = int'(m_hold);
                end
            end else begin
                m_asserted = m_act;
            end
            m_set = m_lvl ? m_s2 : (m_s2 & ~m_prev);
            m_clr = (write && address == 2'd0) ? writedata[N-1:0] : '0;
            m_pend = (m_pend & ~m_clr) | m_set;
            if (write && address == 2'd1) m_mask = writedata[N-1:0];
            if (write && address == 2'd3) begin
                m_en = writedata[0];
                m_lvl = writedata[1];
                m_hold = writedata[31:16];
            end
            m_prev = m_s2;
            m_s2 = m_s1;
            m_s1 = irq_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic quiesce();
        irq_in = '0;
        bus_write(2'd3, 32'h0);
        bus_write(2'd1, 32'h0);
        repeat (4) tick();
        bus_write(2'd0, 32'hFFFF_FFFF);
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0; read = 1'b1; write = 1'b0; address = 2'd0;
        writedata = '0; irq_in = '0;
        repeat (3) tick();
        n_tests++;
        if (readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL reset_rdv_in_reset: got %b want 0", readdatavalid);
        end
        resetn = 1'b1; read = 1'b0;
        tick();
        n_tests++;
        if (irq_out !== 1'b0 || readdatavalid !== 1'b0 || readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: irq=%b rdv=%b rd=%h want 0 0 0", irq_out, readdatavalid, readdata);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            n_tests++;
            if (readdatavalid !== 1'b1 || readdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: rdv=%b rd=%h want 1 00000000", a, readdatavalid, readdata);
            end
        end
    endtask

    task automatic test_edge_latch();
        quiesce();
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'h1);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_tests++;
            if (irq_out !== (k >= 3) || irq_out !== m_asserted) begin
                n_fail++;
                $display("FAIL edge_irq_c%0d: got %b want %b", k, irq_out, (k >= 3));
            end
        end
        bus_read(2'd0);
        n_tests++;
        if (readdata !== 32'h1) begin
            n_fail++; $display("FAIL edge_pending: got %h want 00000001", readdata);
        end
        bus_write(2'd0, 32'h1);
        tick();
        n_tests++;
        if (irq_out !== 1'b0) begin
            n_fail++; $display("FAIL edge_clear_irq: got %b want 0", irq_out);
        end
    endtask

    task automatic test_collision();
        quiesce();
        bus_write(2'd3, 32'h1);
        irq_in[2] = 1'b1;
        tick();
        tick();
        bus_write(2'd0, 32'h4);
        irq_in[2] = 1'b0;
        bus_read(2'd0);
        n_tests++;
        if (readdata[2] !== 1'b1 || readdata !== m_rd) begin
            n_fail++; $display("FAIL collision_set_wins: got %h want bit2 set (%h)", readdata, m_rd);
        end
        bus_write(2'd0, 32'h4);
        bus_read(2'd0);
        n_tests++;
        if (readdata[2] !== 1'b0) begin
            n_fail++; $display("FAIL collision_plain_clear: got %h want bit2 clear", readdata);
        end
    endtask

    task automatic test_holdoff();
        int w;
        int cnt;
        quiesce();
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'h0005_0001);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        w = 0;
        while (irq_out !== 1'b1 && w < 20) begin tick(); w++; end
        n_tests++;
        if (irq_out !== 1'b1) begin
            n_fail++; $display("FAIL holdoff_arm: irq=%b want 1 within 20 cycles", irq_out);
        end
        // clear and retrigger together
        irq_in[0] = 1'b1;
        bus_write(2'd0, 32'h1);
        irq_in[0] = 1'b0;
        cnt = 0;
        w = 0;
        while (w < 40) begin
            tick(); w++;
            n_tests++;
            if (irq_out !== m_asserted) begin
                n_fail++; $display("FAIL holdoff_model: got %b want %b", irq_out, m_asserted);
            end
            if (irq_out === 1'b1) break;
            cnt++;
        end
        n_tests++;
        if (cnt !== 5 || irq_out !== 1'b1) begin
            n_fail++; $display("FAIL holdoff_low_cycles: got %0d (irq=%b) want 5 then high", cnt, irq_out);
        end
        // shrink HOLDOFF while a hold-off is running
        irq_in[0] = 1'b1;
        bus_write(2'd0, 32'h1);
        irq_in[0] = 1'b0;
        cnt = 0;
        tick();
        if (irq_out === 1'b0) cnt++;
        bus_write(2'd3, 32'h0002_0001);
        if (irq_out === 1'b0) cnt++;
        w = 0;
        while (irq_out !== 1'b1 && w < 40) begin
            tick(); w++;
            if (irq_out === 1'b0) cnt++;
        end
        n_tests++;
        if (cnt !== 5 || irq_out !== 1'b1) begin
            n_fail++; $display("FAIL holdoff_change_running: got %0d (irq=%b) want 5 then high", cnt, irq_out);
        end
    endtask

    task automatic test_level();
        int w;
        quiesce();
        bus_write(2'd1, 32'h08);
        bus_write(2'd3, 32'h3);
        irq_in[3] = 1'b1;
        w = 0;
        while (irq_out !== 1'b1 && w < 20) begin tick(); w++; end
        n_tests++;
        if (irq_out !== 1'b1) begin
            n_fail++; $display("FAIL level_arm: irq=%b want 1", irq_out);
        end
        bus_write(2'd0, 32'h8);
        for (int k = 0; k < 4; k++) begin
            tick();
            n_tests++;
            if (irq_out !== 1'b1 || irq_out !== m_asserted) begin
                n_fail++; $display("FAIL level_irq_stays_c%0d: got %b want 1", k, irq_out);
            end
        end
        bus_read(2'd0);
        n_tests++;
        if (readdata !== 32'h8) begin
            n_fail++; $display("FAIL level_pending: got %h want 00000008", readdata);
        end
        irq_in = '0;
    endtask

    task automatic test_mask_disable();
        quiesce();
        bus_write(2'd3, 32'h1);
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        repeat (4) tick();
        bus_read(2'd0);
        n_tests++;
        if (readdata !== 32'h10 || irq_out !== 1'b0) begin
            n_fail++; $display("FAIL mask_off: pend=%h irq=%b want 00000010 0", readdata, irq_out);
        end
        bus_write(2'd1, 32'h10);
        tick();
        n_tests++;
        if (irq_out !== 1'b1) begin
            n_fail++; $display("FAIL mask_on_irq: got %b want 1", irq_out);
        end
        bus_write(2'd3, 32'h0);
        n_tests++;
        if (irq_out !== m_asserted) begin
            n_fail++; $display("FAIL disable_model: got %b want %b", irq_out, m_asserted);
        end
        tick();
        n_tests++;
        if (irq_out !== 1'b0) begin
            n_fail++; $display("FAIL disable_irq: got %b want 0", irq_out);
        end
        bus_read(2'd0);
        n_tests++;
        if (readdata !== 32'h10) begin
            n_fail++; $display("FAIL disable_pending_kept: got %h want 00000010", readdata);
        end
    endtask

    task automatic test_random();
        quiesce();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) irq_in = N'($urandom);
            read  = ($urandom_range(0, 2) == 0);
            write = ($urandom_range(0, 3) == 0);
            address = 2'($urandom);
            writedata = $urandom;
            if (write && address == 2'd3) begin
                writedata[31:16] = 16'($urandom_range(0, 6));
                if ($urandom_range(0, 4) != 0) writedata[0] = 1'b1;
            end
            if (write && address == 2'd1 && $urandom_range(0, 1) == 0) writedata = 32'hFFFF_FFFF;
            tick();
            n_tests++;
            if (irq_out !== m_asserted) begin
                n_fail++; $display("FAIL rand_irq_c%0d: got %b want %b", i, irq_out, m_asserted);
            end
            n_tests++;
            if (readdatavalid !== m_rdv) begin
                n_fail++; $display("FAIL rand_rdv_c%0d: got %b want %b", i, readdatavalid, m_rdv);
            end
            n_tests++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL rand_rdata_c%0d: got %h want %h", i, readdata, m_rd);
            end
        end
        read = 1'b0;
        write = 1'b0;
        irq_in = '0;
    endtask

    task automatic test_reset_mid();
        int w;
        quiesce();
        bus_write(2'd1, 32'h1);
        bus_write(2'd3, 32'h0008_0001);
        irq_in[0] = 1'b1;
        tick();
        irq_in[0] = 1'b0;
        w = 0;
        while (irq_out !== 1'b1 && w < 20) begin tick(); w++; end
        bus_write(2'd0, 32'h1);
        tick();
        n_tests++;
        if (irq_out !== 1'b0 || m_left == 0) begin
            n_fail++; $display("FAIL resetmid_in_holdoff: irq=%b left=%0d want 0 and holding off", irq_out, m_left);
        end
        resetn = 1'b0; read = 1'b1; address = 2'd3;
        tick();
        resetn = 1'b1; read = 1'b0;
        n_tests++;
        if (readdatavalid !== 1'b0 || irq_out !== 1'b0 || readdata !== 32'h0) begin
            n_fail++;
            $display("FAIL resetmid_outputs: rdv=%b irq=%b rd=%h want 0 0 0", readdatavalid, irq_out, readdata);
        end
        tick();
        n_tests++;
        if (readdatavalid !== 1'b0) begin
            n_fail++; $display("FAIL resetmid_discarded_read: rdv=%b want 0", readdatavalid);
        end
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            n_tests++;
            if (readdata !== 32'h0) begin
                n_fail++; $display("FAIL resetmid_reg%0d: got %h want 00000000", a, readdata);
            end
        end
        // a source already high at reset release counts as an edge
        irq_in[1] = 1'b1;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        repeat (4) tick();
        bus_read(2'd0);
        n_tests++;
        if (readdata !== 32'h2) begin
            n_fail++; $display("FAIL reset_release_edge: got %h want 00000002", readdata);
        end
        irq_in = '0;
    endtask

    initial begin
        test_reset();
        test_edge_latch();
        test_collision();
        test_holdoff();
        test_level();
        test_mask_disable();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_aggregator_slave.md
IRQ_AGGREGATOR_SLAVE -- requirements
Module: irq_aggregator_slave

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 8, number of interrupt sources (legal range 1..32).
REQ-002 SHALL provide parameter DATA_WIDTH, default 32, slave data width (fixed at 32).
REQ-003 SHALL provide port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide port resetn  input  1  synchronous, active-low reset.
REQ-005 SHALL provide port irq_in  input  NUM_IRQ  level interrupt sources, asynchronous to clk.
REQ-006 SHALL provide port address  input  2  register word select.
REQ-007 SHALL provide port read  input  1  read strobe.
REQ-008 SHALL provide port write  input  1  write strobe.
REQ-009 SHALL provide port writedata  input  32  write data.
REQ-010 SHALL provide port readdata  output  32  read data.
REQ-011 SHALL provide port readdatavalid  output  1  read data qualifier.
REQ-012 SHALL provide port irq_out  output  1  aggregated interrupt to host.

Function
REQ-013 SHALL synchronize irq_in through two flops per bit; sync_irq is the second-stage value.
REQ-014 SHALL set PENDING[i] on a 0->1 transition of sync_irq[i] when CTRL.LEVEL=0, and on every cycle sync_irq[i]=1 when CTRL.LEVEL=1.
REQ-015 SHALL clear PENDING[i] on a write to address 0 with writedata[i]=1 (W1C); writedata bits =0 leave bits unchanged.
REQ-016 SHALL give set priority over clear when both occur on PENDING[i] in the same cycle.
REQ-017 SHALL implement register map: 0 PENDING (RW1C), 1 MASK (RW, 1=enabled), 2 RAW sync_irq (RO), 3 CTRL (RW: bit0 ENABLE, bit1 LEVEL, bits31:16 HOLDOFF).
REQ-018 SHALL ignore writes to address 2 and to bits above NUM_IRQ-1 in addresses 0..2; those bits read 0; CTRL bits 15:2 read 0.
REQ-019 SHALL return read data exactly one cycle after read, readdatavalid high for exactly that cycle, readdata holding last value otherwise.
REQ-020 SHALL return the pre-write register value when read and write target the same address in the same cycle.
REQ-021 SHALL compute active = ENABLE & |(PENDING & MASK).
REQ-022 SHALL run a state machine IDLE, ASSERT, HOLDOFF controlling irq_out (registered; high only in ASSERT).
REQ-023 IDLE -> ASSERT when active=1; irq_out rises the cycle after active first goes high.
REQ-024 ASSERT -> HOLDOFF when active=0 and HOLDOFF!=0, loading a 16-bit down-counter with HOLDOFF; ASSERT -> IDLE when active=0 and HOLDOFF=0.
REQ-025 HOLDOFF: counter decrements each cycle; -> IDLE when counter reaches 0 (irq_out low for exactly HOLDOFF cycles min); new active in HOLDOFF SHALL NOT raise irq_out early but SHALL be honored from IDLE.
REQ-026 Writing CTRL.ENABLE=0 SHALL force state to IDLE, clear the counter, and drop irq_out next cycle; PENDING continues to latch.
REQ-027 Changing HOLDOFF during HOLDOFF SHALL NOT affect the running count.

Reset
REQ-028 While resetn=0 at a clock edge: PENDING=0, MASK=0, CTRL=0, synchronizer flops=0, state=IDLE, counter=0, irq_out=0, readdatavalid=0, readdata=0.
REQ-029 A read issued in the cycle resetn is low SHALL be discarded (no readdatavalid afterwards).
REQ-030 First edge detection after reset SHALL compare against the reset value 0, so a source already high at reset release sets PENDING in edge mode.

Verification
REQ-031 Edge latch: MASK=0x01, CTRL=0x1, pulse irq_in[0] one cycle -> PENDING=0x01 3 cycles later, irq_out=1 one cycle after; write 0x01 to addr 0 -> irq_out=0 next cycle.
REQ-032 Set/clear collision: W1C of bit 2 in the same cycle as sync edge on bit 2 -> PENDING[2]=1 afterwards.
REQ-033 Holdoff: CTRL=0x0005_0001, clear then retrigger immediately -> irq_out low exactly 5 cycles, then high.
REQ-034 Level mode: CTRL=0x3, hold irq_in[3]=1, W1C bit 3 -> PENDING[3] re-sets next cycle, irq_out stays 1.
REQ-035 Masking/disable: PENDING=0x10, MASK=0 -> irq_out=0; set MASK=0x10 -> irq_out=1; write CTRL.ENABLE=0 -> irq_out=0 next cycle, PENDING still 0x10.
REQ-036 Reset mid-operation: assert resetn=0 in HOLDOFF with read pending -> all registers 0, no readdatavalid, irq_out=0.
